// File: rtl/execute_ctl_q.sv
// Decode-to-execute control stage: RV32I controls decoded at enqueue into a DEPTH-entry elastic buffer.
// Latency: one cycle from push to head; no combinational path from inputs to outputs.
// Backpressure: in_ready drops when the buffer is full; the head is held until out_ready; flush/reset empty it.
module execute_ctl_q #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_de,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] data_a,
  input  logic [XLEN-1:0] data_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      a_sel,
  output logic            b_sel,
  output logic [3:0]      immSel,
  output logic [3:0]      alu_sel,
  output logic            sign,
  output logic [2:0]      br_expect,
  output logic            jump,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [1:0]      mem_size,
  output logic            illegal,
  output logic [XLEN-1:0] data_a_exe,
  output logic [XLEN-1:0] data_b_exe,
  output logic [XLEN-1:0] pc_exe,
  output logic [31:0]     instr_exe
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [1:0] a_sel;
    logic       b_sel;
    logic [3:0] imm_sel;
    logic [3:0] alu_sel;
    logic       sign;
    logic [2:0] br_expect;
    logic       jump;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] mem_size;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    ctl_t            ctl;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } bundle_t;

  localparam ctl_t ILL_CTL = '{a_sel: 2'd0, b_sel: 1'b0, imm_sel: 4'd0, alu_sel: 4'd0, sign: 1'b0,
                               br_expect: 3'd0, jump: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0,
                               mem_size: 2'd0, illegal: 1'b1};
  // Empty-buffer presentation: an ADDI x0,x0,0 bubble that passes the immediate through.
  localparam ctl_t BUB_CTL = '{a_sel: 2'd0, b_sel: 1'b1, imm_sel: 4'd0, alu_sel: 4'd6, sign: 1'b0,
                               br_expect: 3'd0, jump: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0,
                               mem_size: 2'd2, illegal: 1'b0};
  localparam bundle_t BUBBLE = '{ctl: BUB_CTL, pc: RESET_PC, instr: 32'h00000013, a: '0, b: '0};

  bundle_t         r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  ctl_t            w_dec, w_ctl;
  logic            w_bad, w_push, w_pop;
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  bundle_t         w_head;

  assign w_op = instruction[6:0];
  assign w_f3 = instruction[14:12];
  assign w_f7 = instruction[31:25];

  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Decode the incoming instruction into execute controls; undecodable encodings flag w_bad.
  always_comb begin
    w_dec = '0;
    w_bad = 1'b0;
    case (w_op)
      7'b0110111: begin w_dec.b_sel = 1'b1; w_dec.imm_sel = 4'd4; w_dec.alu_sel = 4'd6; end
      7'b0010111: begin
        w_dec.a_sel = 2'd1; w_dec.b_sel = 1'b1; w_dec.imm_sel = 4'd4; w_dec.alu_sel = 4'd3;
      end
      7'b1101111: begin
        w_dec.a_sel = 2'd1; w_dec.b_sel = 1'b1; w_dec.imm_sel = 4'd5; w_dec.alu_sel = 4'd3;
        w_dec.sign = 1'b1; w_dec.jump = 1'b1;
      end
      7'b1100111: begin
        w_dec.b_sel = 1'b1; w_dec.imm_sel = 4'd1; w_dec.alu_sel = 4'd3;
        w_dec.sign = 1'b1; w_dec.jump = 1'b1;
        w_bad = (w_f3 != 3'b000);
      end
      7'b1100011: begin
        w_dec.a_sel = 2'd1; w_dec.b_sel = 1'b1; w_dec.imm_sel = 4'd3; w_dec.alu_sel = 4'd3;
        w_dec.sign = 1'b1;
        case (w_f3)
          3'b000:  w_dec.br_expect = 3'd1;
          3'b001:  w_dec.br_expect = 3'd2;
          3'b100:  w_dec.br_expect = 3'd3;
          3'b101:  w_dec.br_expect = 3'd4;
          3'b110:  w_dec.br_expect = 3'd5;
          3'b111:  w_dec.br_expect = 3'd6;
          default: w_bad = 1'b1;
        endcase
      end
      7'b0000011: begin
        w_dec.b_sel = 1'b1; w_dec.imm_sel = 4'd1; w_dec.alu_sel = 4'd3; w_dec.mem_rd = 1'b1;
        w_dec.mem_size = w_f3[1:0];
        w_dec.sign = ~w_f3[2];
        w_bad = !(w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      7'b0100011: begin
        w_dec.b_sel = 1'b1; w_dec.imm_sel = 4'd2; w_dec.alu_sel = 4'd3; w_dec.sign = 1'b1;
        w_dec.mem_wr = 1'b1; w_dec.mem_size = w_f3[1:0];
        w_bad = !(w_f3 inside {3'b000, 3'b001, 3'b010});
      end
      7'b0010011: begin
        w_dec.b_sel = 1'b1; w_dec.imm_sel = 4'd1; w_dec.sign = 1'b1;
        case (w_f3)
          3'b000: w_dec.alu_sel = 4'd3;
          3'b010: w_dec.alu_sel = 4'd12;
          3'b011: w_dec.alu_sel = 4'd11;
          3'b100: w_dec.alu_sel = 4'd2;
          3'b110: w_dec.alu_sel = 4'd1;
          3'b111: w_dec.alu_sel = 4'd0;
          3'b001: begin w_dec.alu_sel = 4'd7; w_dec.sign = 1'b0; w_bad = (w_f7 != 7'b0000000); end
          default: begin
            w_dec.sign = 1'b0;
            if (w_f7 == 7'b0000000)      w_dec.alu_sel = 4'd8;
            else if (w_f7 == 7'b0100000) w_dec.alu_sel = 4'd10;
            else                         w_bad = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        case (w_f3)
          3'b000: begin
            if (w_f7 == 7'b0000000)      w_dec.alu_sel = 4'd3;
            else if (w_f7 == 7'b0100000) w_dec.alu_sel = 4'd4;
            else                         w_bad = 1'b1;
          end
          3'b101: begin
            if (w_f7 == 7'b0000000)      w_dec.alu_sel = 4'd8;
            else if (w_f7 == 7'b0100000) w_dec.alu_sel = 4'd10;
            else                         w_bad = 1'b1;
          end
          3'b001: begin w_dec.alu_sel = 4'd7;  w_bad = (w_f7 != 7'b0000000); end
          3'b010: begin w_dec.alu_sel = 4'd12; w_bad = (w_f7 != 7'b0000000); end
          3'b011: begin w_dec.alu_sel = 4'd11; w_bad = (w_f7 != 7'b0000000); end
          3'b100: begin w_dec.alu_sel = 4'd2;  w_bad = (w_f7 != 7'b0000000); end
          3'b110: begin w_dec.alu_sel = 4'd1;  w_bad = (w_f7 != 7'b0000000); end
          default: begin w_dec.alu_sel = 4'd0; w_bad = (w_f7 != 7'b0000000); end
        endcase
      end
      7'b0001111: ;
      7'b1110011: w_bad = !(instruction[31:20] == 12'd0 || instruction[31:20] == 12'd1);
      default:    w_bad = 1'b1;
    endcase
  end

  // An illegal beat carries no controls at all, only the flag.
  assign w_ctl = w_bad ? ILL_CTL : w_dec;

  // Capture the decoded bundle into the tail slot on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{ctl: w_ctl, pc: pc_de, instr: instruction, a: data_a, b: data_b};
  end

  // Pointer and occupancy bookkeeping; reset beats flush, flush beats handshakes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // Present the head bundle, or the bubble while empty.
  always_comb begin
    w_head = BUBBLE;
    if (out_valid) w_head = r_mem[r_rd_ptr];
  end

  assign a_sel      = w_head.ctl.a_sel;
  assign b_sel      = w_head.ctl.b_sel;
  assign immSel     = w_head.ctl.imm_sel;
  assign alu_sel    = w_head.ctl.alu_sel;
  assign sign       = w_head.ctl.sign;
  assign br_expect  = w_head.ctl.br_expect;
  assign jump       = w_head.ctl.jump;
  assign mem_rd     = w_head.ctl.mem_rd;
  assign mem_wr     = w_head.ctl.mem_wr;
  assign mem_size   = w_head.ctl.mem_size;
  assign illegal    = w_head.ctl.illegal;
  assign pc_exe     = w_head.pc;
  assign instr_exe  = w_head.instr;
  assign data_a_exe = w_head.a;
  assign data_b_exe = w_head.b;

endmodule

// File: doc/execute_ctl_q.md
Name: execute_ctl_q

Overview:
- Parametrised decode-to-execute control stage with a DEPTH-entry elastic buffer.
- Accepts decoded-stage beats (pc, instruction, operand data) over a valid/ready handshake, and fully decodes RV32I execute controls at enqueue.
- Presents the oldest beat to execute over a second valid/ready handshake.
- Adds over the single-register stage: backpressure without a global stall, pipeline flush, illegal-instruction flag, and explicit memory/jump controls.

Parameters:
- XLEN, 32, width of data and pc paths.
- DEPTH, 2, buffer entries (≥1).
- RESET_PC, 32'h0, pc_exe value presented while empty or after reset.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- in_valid  input  1  upstream beat valid
- in_ready  output  1  buffer can accept
- flush  input  1  discard all held and incoming beats
- pc_de  input  XLEN  pc of incoming instruction
- instruction  input  32  incoming instruction
- data_a, data_b  input  XLEN  rs1/rs2 operand values
- out_valid  output  1  head beat valid
- out_ready  input  1  execute consumes head
- a_sel  output  2  0 = rs1, 1 = pc
- b_sel  output  1  0 = rs2, 1 = immediate
- immSel  output  4  0 none, 1 I, 2 S, 3 B, 4 U, 5 J
- alu_sel  output  4  0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 6 PASSB, 7 SLL, 8 SRL, 10 SRA, 11 SLTU, 12 SLT
- sign  output  1  sign-extend immediate/load
- br_expect  output  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU
- jump  output  1  JAL/JALR
- mem_rd, mem_wr  output  1  load / store
- mem_size  output  2  0 byte, 1 half, 2 word
- illegal  output  1  undecodable instruction
- data_a_exe, data_b_exe, pc_exe  output  XLEN  head operands and pc
- instr_exe  output  32  head instruction

Behaviour:
- Storage and handshake
  - Storage is a circular buffer of decoded bundles with wr_ptr, rd_ptr and count (width clog2(DEPTH+1)).
  - in_ready = (count != DEPTH), combinational from registered count only.
  - out_valid = (count != 0).
  - Push when in_valid & in_ready & !flush. Pop when out_valid & out_ready & !flush.
  - Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap at DEPTH−1 → 0.
- Latency
  - A beat pushed at edge N appears at the outputs with out_valid = 1 after edge N, provided it is the head.
  - No combinational path from in_* to out_*.
- Empty state
  - While count = 0, all outputs present the bubble bundle with out_valid = 0.
  - Bubble bundle: a_sel 0, b_sel 1, immSel 0, alu_sel 6, sign 0, br_expect 0, jump/mem_rd/mem_wr/illegal 0, mem_size 2, pc_exe RESET_PC, instr_exe 32'h00000013, data 0.
- Flush
  - Count goes to 0 and rd_ptr = wr_ptr.
  - Any same-cycle push or pop is ignored.
  - out_valid = 0 the next cycle.
- Reset (rst = 0 at an edge)
  - Same as flush; also zeroes the pointers.
  - Overrides flush and handshakes, including mid-stream.
- Decode (performed at push; fields default to 0 unless listed)
  - LUI 0110111: b 1, imm 4, alu 6.
  - AUIPC 0010111: a 1, b 1, imm 4, alu 3.
  - JAL 1101111: a 1, b 1, imm 5, alu 3, sign 1, jump 1.
  - JALR 1100111 (funct3 000): b 1, imm 1, alu 3, sign 1, jump 1.
  - BRANCH 1100011: a 1, b 1, imm 3, alu 3, sign 1.
    - funct3 → br_expect: 000→1, 001→2, 100→3, 101→4, 110→5, 111→6.
    - funct3 010/011 → illegal.
  - LOAD 0000011: b 1, imm 1, alu 3, mem_rd 1, mem_size = funct3[1:0].
    - sign 1 for 000/001/010, sign 0 for 100/101.
    - Other funct3 → illegal.
  - STORE 0100011: b 1, imm 2, alu 3, sign 1, mem_wr 1, mem_size = funct3[1:0].
    - funct3 000/001/010 valid; others illegal.
  - OP-IMM 0010011: b 1, imm 1.
    - alu by funct3: 000→3, 010→12, 011→11, 100→2, 110→1, 111→0, 001→7, 101→8 (funct7 0000000) or 10 (funct7 0100000).
    - sign 1 except shifts.
    - Shift with any other funct7 → illegal.
  - OP 0110011: b 0, imm 0.
    - alu by funct3: 000→3 (funct7 0000000) or 4 (0100000), 001→7, 010→12, 011→11, 100→2, 101→8 or 10 by funct7, 110→1, 111→0.
    - funct7 other than 0000000 (or 0100000 where allowed) → illegal.
  - FENCE 0001111, SYSTEM 1110011 with instr[31:20] of 0 or 1: all zero, legal.
  - Any other encoding: all control zero, illegal 1.
  - The beat is still enqueued and instr_exe is preserved.

Test Plan:
- Reset: hold rst = 0 for 2 cycles, then release → out_valid 0, in_ready 1, pc_exe RESET_PC, alu_sel 6, instr_exe 32'h00000013.
- Fill/backpressure, DEPTH = 2: push ADDI 0x00500093 then ADD 0x002081B3 with out_ready = 0 → in_ready 0 after 2nd edge; head shows alu 3, b_sel 1, immSel 1, sign 1.
- Drain: then set out_ready = 1 → ADD head with b_sel 0, alu 3, then out_valid 0.
- Simultaneous push/pop at count 1 for 10 cycles → count stays 1, order preserved, pointers wrap.
- Flush: flush = 1 while count 2 and in_valid = 1 → out_valid 0 next cycle; the incoming beat is never output.
- Decode sweep:
  - JALR 0x000080E7 → jump 1, a_sel 0, alu 3.
  - BLT 0x0020C463 → br_expect 3.
  - SRA 0x4020D1B3 → alu 10.
  - LHU 0x0000D083 → mem_rd 1, mem_size 1, sign 0.
  - 0xFFFFFFFF → illegal 1.
- Reset mid-stream: rst = 0 at count 2 with a push and pop active → next cycle count 0, bubble bundle presented.
